// File: rtl/inv_rotate_pkg.sv
// Shared encoder/decoder definitions for the 64-slice x 25-lane state:
// geometry, the per-lane z-rotation table and the stage FSM encoding.
package inv_rotate_pkg;

    localparam int LANES  = 25;
    localparam int SLICES = 64;
    localparam int AW     = 6;

    // Lane i = 5*y + x; the forward stage rotates lane i by +ROT_OFF[i] along z.
    localparam logic [AW-1:0] ROT_OFF [LANES] = '{
        6'd0,  6'd1,  6'd62, 6'd28, 6'd27,
        6'd36, 6'd44, 6'd6,  6'd55, 6'd20,
        6'd3,  6'd10, 6'd43, 6'd25, 6'd39,
        6'd41, 6'd45, 6'd15, 6'd21, 6'd8,
        6'd18, 6'd2,  6'd61, 6'd56, 6'd14
    };

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/inv_rotate_slice_gather.sv
// Forms one un-rotated output slice z from the buffered state:
// out[z][i] = state[(z + ROT_OFF[i]) mod 64][i], with the mod falling out of the 6-bit add.
module slice_gather
    import inv_rotate_pkg::*;
(
    input  logic [AW-1:0]    z,
    input  logic [LANES-1:0] slices [SLICES],
    output logic [LANES-1:0] slice
);

    always_comb begin
        slice = '0;
        for (int i = 0; i < LANES; i++) begin
            slice[i] = slices[AW'(z + ROT_OFF[i])][i];
        end
    end

endmodule

// File: rtl/inv_rotate.sv
// Decoder inverse lane-rotate: loads 64 slices from upstream RAM, then writes the un-rotated state.
// Optional build macro INV_ROTATE_PARITY_EN adds parity_out, the XOR of all words written in the last pass.
module inv_rotate
    import inv_rotate_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    output logic [AW-1:0]    rd_addr,
    input  logic [LANES-1:0] rd_data,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [LANES-1:0] wr_data
`ifdef INV_ROTATE_PARITY_EN
    ,
    output logic [LANES-1:0] parity_out
`endif
);

    state_t           state;
    state_t           state_next;
    logic             take_start;
    logic             load_last;
    logic             write_last;

    logic [LANES-1:0] slice_buf   [SLICES];
    logic [LANES-1:0] gather_view [SLICES];
    logic [AW-1:0]    gather_z;
    logic [LANES-1:0] gather_slice;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        take_start = 1'b0;
        load_last  = (rd_addr == AW'(SLICES - 1));
        write_last = (wr_addr == AW'(SLICES - 1));
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    take_start = 1'b1;
                end
            end
            ST_LOAD:  if (load_last) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_WRITE;
            ST_WRITE: if (write_last) state_next = ST_DONE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // RAM data lags its address by one cycle, so each capture lands one slot behind rd_addr.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD && rd_addr != '0) begin
            slice_buf[rd_addr - AW'(1)] <= rd_data;
        end else if (state == ST_DRAIN) begin
            slice_buf[SLICES-1] <= rd_data;
        end
    end

    // Slice 63 is still on rd_data during DRAIN, yet the first output word must be registered then.
    always_comb begin
        gather_view = slice_buf;
        if (state == ST_DRAIN) begin
            gather_view[SLICES-1] = rd_data;
        end
        gather_z = (state == ST_DRAIN) ? '0 : wr_addr + AW'(1);
    end

    slice_gather u_gather (
        .z      (gather_z),
        .slices (gather_view),
        .slice  (gather_slice)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ready   <= 1'b0;
            wr_en   <= 1'b0;
            rd_addr <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (take_start) begin
                        ready   <= 1'b0;
                        rd_addr <= '0;
                    end
                end
                ST_LOAD: rd_addr <= rd_addr + AW'(1);
                ST_DRAIN: begin
                    wr_en   <= 1'b1;
                    wr_addr <= '0;
                    wr_data <= gather_slice;
                end
                ST_WRITE: begin
                    if (write_last) begin
                        wr_en <= 1'b0;
                        ready <= 1'b1;
                    end else begin
                        wr_addr <= wr_addr + AW'(1);
                        wr_data <= gather_slice;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef INV_ROTATE_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst || take_start) begin
            parity_out <= '0;
        end else if (wr_en) begin
            parity_out <= parity_out ^ wr_data;
        end
    end
`endif

endmodule

// File: tb/tb_inv_rotate.sv
// Randomized bench for inv_rotate: upstream RAM model, write logger and a direct
// formula reference out[z][i] = in[(z + OFF[i]) mod 64][i].
module tb_inv_rotate;

    localparam int OFF [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                                41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [5:0]  rd_addr;
    logic [24:0] rd_data;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [24:0] wr_data;
`ifdef INV_ROTATE_PARITY_EN
    logic [24:0] parity_out;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [24:0] in_mem  [64];
    logic [24:0] exp_mem [64];
    logic [24:0] orig    [64];
    int          wr_addr_q [$];
    logic [24:0] wr_data_q [$];
    int          base;

    inv_rotate dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ready   (ready),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
`ifdef INV_ROTATE_PARITY_EN
        ,
        .parity_out (parity_out)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= in_mem[rd_addr];

    always @(negedge clk) begin
        if (wr_en) begin
            wr_addr_q.push_back(int'(wr_addr));
            wr_data_q.push_back(wr_data);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic buildExpected();
        for (int z = 0; z < 64; z++) begin
            for (int i = 0; i < 25; i++) begin
                exp_mem[z][i] = in_mem[(z + OFF[i]) % 64][i];
            end
        end
    endtask

    // Randomize a target state and store its forward rotation upstream; the target is the expectation.
    task automatic forwardRandom();
        for (int z = 0; z < 64; z++) orig[z] = 25'($urandom);
        for (int z = 0; z < 64; z++) begin
            for (int i = 0; i < 25; i++) begin
                in_mem[z][i] = orig[(z - OFF[i] + 64) % 64][i];
            end
        end
        for (int z = 0; z < 64; z++) exp_mem[z] = orig[z];
    endtask

    task automatic applyStimulus(input int pulse_k);
        int k;
        int wr_first_k;
        int ready_k;
        int n;
        logic [24:0] px;
        base       = wr_addr_q.size();
        wr_first_k = -1;
        ready_k    = -1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 1;
        checkOutput("ready_low_after_start", 32'(ready), 32'd0);
        checkOutput("rd_addr_first", 32'(rd_addr), 32'd0);
        while (ready_k < 0 && k < 400) begin
            if (wr_en && wr_first_k < 0) wr_first_k = k;
            if (ready) begin
                ready_k = k;
            end else begin
                @(negedge clk);
                k++;
                start = (k == pulse_k);
            end
        end
        start = 1'b0;
        checkOutput("first_wr_cycle", 32'(wr_first_k), 32'd66);
        checkOutput("ready_cycle", 32'(ready_k), 32'd130);
        n = wr_addr_q.size() - base;
        checkOutput("write_count", 32'(n), 32'd64);
        for (int j = 0; j < n && j < 64; j++) begin
            checkOutput($sformatf("wr_addr[%0d]", j), 32'(wr_addr_q[base + j]), 32'(j));
            checkOutput($sformatf("wr_data[%0d]", j), 32'(wr_data_q[base + j]), 32'(exp_mem[j]));
        end
        px = '0;
        for (int z = 0; z < 64; z++) px ^= exp_mem[z];
`ifdef INV_ROTATE_PARITY_EN
        checkOutput("parity_out", 32'(parity_out), 32'(px));
`endif
    endtask

    function automatic logic [24:0] writtenAt(input int j);
        if (wr_addr_q.size() > base + j) return wr_data_q[base + j];
        return 'x;
    endfunction

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int z = 0; z < 64; z++) in_mem[z] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'd0);

        $display("[TB] all-zero state");
        buildExpected();
        applyStimulus(0);

        $display("[TB] single bits in slice 0");
        in_mem[0] = 25'h0000002;
        buildExpected();
        applyStimulus(0);
        checkOutput("bit1_slice63", 32'(writtenAt(63)), 32'h0000002);
        checkOutput("bit1_slice0", 32'(writtenAt(0)), 32'h0);
        in_mem[0] = 25'h0000004;
        buildExpected();
        applyStimulus(0);
        checkOutput("bit2_slice2", 32'(writtenAt(2)), 32'h0000004);

        $display("[TB] lane 0 passthrough");
        for (int z = 0; z < 64; z++) in_mem[z] = 25'(z % 2);
        buildExpected();
        applyStimulus(0);
        checkOutput("lane0_z5", 32'(writtenAt(5)), 32'h1);
        checkOutput("lane0_z6", 32'(writtenAt(6)), 32'h0);

        $display("[TB] forward/inverse round trips");
        for (int s = 0; s < 100; s++) begin
            forwardRandom();
            applyStimulus(0);
        end

        $display("[TB] reset mid-load");
        forwardRandom();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (29) @(negedge clk);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        checkOutput("midrst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("midrst_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("midrst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("midrst_ready", 32'(ready), 32'd0);
        base = wr_addr_q.size();
        repeat (150) @(negedge clk);
        checkOutput("midrst_no_writes", 32'(wr_addr_q.size() - base), 32'd0);
        applyStimulus(0);

        $display("[TB] start pulsed during write and drain");
        forwardRandom();
        applyStimulus(100);
        forwardRandom();
        applyStimulus(65);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
